// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end.
//   INSTR_W / ADDR_W : default instruction and word-address widths
//   OPC_W / OPC_LSB  : opcode field width and position inside an instruction
//   fetch_state_t    : fetch sequencer states
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int OPC_W   = 4;
  localparam int OPC_LSB = INSTR_W - OPC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push/wdata      : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   flush           : empty the queue; wins over push/pop
//   rdata           : head entry, forced to zero while empty
//   count/full/empty: occupancy status
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Zero the head while empty so stale entries never leak downstream.
  assign rdata = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one request at a time to a
// variable-latency instruction memory and buffers returned words for the decoder.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   redirect_valid/redirect_pc  : restart fetch at a new target (flushes queue)
//   imem_req/imem_addr/imem_gnt : request channel to instruction memory
//   imem_rvalid/imem_rdata      : in-order response channel
//   instr_valid/instr_ready     : handshake toward the decoder
//   instr/instr_pc              : head instruction word and its word address
module instr_fetch_unit #(
  parameter int                  INSTR_W  = cpu_pkg::INSTR_W,
  parameter int                  ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                  QDEPTH   = 2,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  import cpu_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t              state;
  logic [ADDR_W-1:0]         fetch_pc, req_pc;
  logic                      discard;
  logic                      granted;
  logic                      q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]             q_count;
  logic [CW:0]               credit_used;
  logic [INSTR_W+ADDR_W-1:0] q_rdata;

  // Queued words plus the in-flight one must leave room for the response.
  assign credit_used = {1'b0, q_count} + {{CW{1'b0}}, (state == WAIT)};
  assign imem_req    = (state == REQ) && (credit_used < (CW+1)'(QDEPTH));
  assign imem_addr   = fetch_pc;
  assign granted     = imem_req && imem_gnt;

  // A response coinciding with a redirect belongs to the old stream.
  assign q_push      = (state == WAIT) && imem_rvalid && !discard && !redirect_valid && !q_full;
  assign q_pop       = instr_valid && instr_ready;
  assign instr_valid = !q_empty;
  assign {instr, instr_pc} = q_rdata;

  fetch_queue #(
    .W     (INSTR_W + ADDR_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, req_pc}),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      if (granted) req_pc <= fetch_pc;
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (granted) begin
            state    <= WAIT;
            fetch_pc <= fetch_pc + 1'b1;
            // Granted alongside a redirect: its response is already stale.
            discard  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state   <= REQ;
            discard <= 1'b0;
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Redirect target overrides any PC increment made above.
      if (redirect_valid) fetch_pc <= redirect_pc;
    end
  end

endmodule
